// File: rtl/mii_pkg.sv
// Shared definitions for the MII command receiver:
// rx FSM states, CRC constants, framing nibbles, field offsets.
package mii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_BODY,
        ST_DROP
    } rx_state_t;

    localparam logic [31:0] CRC_POLY    = 32'hedb88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hdebb20e3;

    localparam logic [3:0] NIB_PRE = 4'h5;
    localparam logic [3:0] NIB_SFD = 4'hd;

    localparam int OFS_TYPE_LO = 12;
    localparam int OFS_TYPE_HI = 13;
    localparam int OFS_SEQ     = 14;
    localparam int OFS_OPC     = 15;
    localparam int OFS_CMD0    = 16;
    localparam int OFS_CMD1    = 17;
    localparam int OFS_CMD2    = 18;

    // 19 header/field bytes plus 4 FCS bytes
    localparam int MIN_BYTES = 23;

endpackage

// File: rtl/mii_cmd_rx_if.sv
// Bundle between the PHY receive pins and the command outputs.
// master: receiver side; slave: PHY/consumer side.
interface mii_cmd_rx_if;
    logic [3:0]  mii_D;
    logic        mii_DV;
    logic [19:0] command;
    logic [2:0]  opcode;
    logic [7:0]  seqnum;
    logic        strobe;
    logic        tx_strobe;
    logic [15:0] good_count;
    logic [15:0] bad_count;

    modport master (
        input  mii_D, mii_DV,
        output command, opcode, seqnum,
        output strobe, tx_strobe,
        output good_count, bad_count
    );

    modport slave (
        output mii_D, mii_DV,
        input  command, opcode, seqnum,
        input  strobe, tx_strobe,
        input  good_count, bad_count
    );
endinterface

// File: rtl/mii_crc32_nibble.sv
// Reflected CRC-32 step over one nibble, LSB first.
// Ports: crc_in (32), nibble (4) -> crc_out (32). Combinational.
module mii_crc32_nibble
    import mii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nibble,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 4; i++) begin
            if (crc_out[0] ^ nibble[i])
                crc_out = (crc_out >> 1) ^ CRC_POLY;
            else
                crc_out = crc_out >> 1;
        end
    end

endmodule

// File: rtl/mii_cmd_rx.sv
// MII receive: preamble/SFD hunt, byte assembly, FCS and type check,
// command latch. Ports: clk, reset, bus (mii_D/mii_DV in; fields, strobes, counters out).
module mii_cmd_rx
    import mii_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE = 16'h5555,
    parameter int          MAX_BYTES = 1518
) (
    input logic          clk,
    input logic          reset,
    mii_cmd_rx_if.master bus
);

    localparam int BCW = $clog2(MAX_BYTES + 1);

    // Pin register: plain pipeline stage, not reset, so the FSM
    // sees the live DV level right after reset releases.
    logic [3:0] d_r;
    logic       dv_r;

    always_ff @(posedge clk) begin
        d_r  <= bus.mii_D;
        dv_r <= bus.mii_DV;
    end

    rx_state_t state, state_nx;

    logic [31:0]    crc;
    logic [31:0]    crc_next;
    logic [BCW-1:0] byte_cnt;
    logic           nib_hi;
    logic [3:0]     lo_nib;
    logic [7:0]     rx_byte;

    logic [7:0]  type_lo, type_hi;
    logic [7:0]  seq_sh;
    logic [2:0]  op_sh;
    logic [19:0] cmd_sh;

    logic frame_end;
    logic overflow;
    logic frame_ok;
    logic sfd_hit;

    logic        commit_good, commit_bad;
    logic [19:0] cmd_q;
    logic [2:0]  op_q;
    logic [7:0]  seq_q;
    logic        stb_q, tx_stb_q;
    logic [15:0] good_q, bad_q;

    mii_crc32_nibble u_crc (
        .crc_in  (crc),
        .nibble  (d_r),
        .crc_out (crc_next)
    );

    assign rx_byte = {d_r, lo_nib};
    assign sfd_hit = (state == ST_PREAMBLE) && dv_r
                  && (d_r == NIB_SFD);

    assign frame_ok = (byte_cnt >= BCW'(MIN_BYTES))
                   && !nib_hi
                   && ({type_hi, type_lo} == ETHERTYPE)
                   && (crc == CRC_RESIDUE);

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_DROP;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        frame_end = 1'b0;
        overflow  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (dv_r)
                    state_nx = (d_r == NIB_PRE) ? ST_PREAMBLE
                                                : ST_DROP;
            end
            ST_PREAMBLE: begin
                if (!dv_r)
                    state_nx = ST_IDLE;
                else if (d_r == NIB_SFD)
                    state_nx = ST_BODY;
                else if (d_r != NIB_PRE)
                    state_nx = ST_DROP;
            end
            ST_BODY: begin
                if (!dv_r) begin
                    frame_end = 1'b1;
                    state_nx  = ST_IDLE;
                end else if (nib_hi
                          && byte_cnt == BCW'(MAX_BYTES)) begin
                    // this nibble completes byte MAX_BYTES+1
                    overflow = 1'b1;
                    state_nx = ST_DROP;
                end
            end
            ST_DROP: begin
                if (!dv_r)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_DROP;
        endcase
    end

    // Byte assembler, CRC and field shadows. Shadows are only read
    // at commit, which happens before the next BODY can start.
    always_ff @(posedge clk) begin
        if (sfd_hit) begin
            crc      <= '1;
            byte_cnt <= '0;
            nib_hi   <= 1'b0;
        end else if (state == ST_BODY && dv_r) begin
            crc    <= crc_next;
            nib_hi <= ~nib_hi;
            if (!nib_hi) begin
                lo_nib <= d_r;
            end else begin
                byte_cnt <= byte_cnt + 1'b1;
                case (byte_cnt)
                    BCW'(OFS_TYPE_LO): type_lo <= rx_byte;
                    BCW'(OFS_TYPE_HI): type_hi <= rx_byte;
                    BCW'(OFS_SEQ):     seq_sh  <= rx_byte;
                    BCW'(OFS_OPC):     op_sh   <= rx_byte[2:0];
                    BCW'(OFS_CMD0):    cmd_sh[7:0]   <= rx_byte;
                    BCW'(OFS_CMD1):    cmd_sh[15:8]  <= rx_byte;
                    BCW'(OFS_CMD2):    cmd_sh[19:16] <= rx_byte[3:0];
                    default: ;
                endcase
            end
        end
    end

    // Verdict is registered, then applied one edge later.
    always_ff @(posedge clk) begin
        if (reset) begin
            commit_good <= 1'b0;
            commit_bad  <= 1'b0;
            cmd_q       <= '0;
            op_q        <= '0;
            seq_q       <= '0;
            stb_q       <= 1'b0;
            tx_stb_q    <= 1'b0;
            good_q      <= '0;
            bad_q       <= '0;
        end else begin
            commit_good <= frame_end && frame_ok;
            commit_bad  <= (frame_end && !frame_ok) || overflow;
            if (commit_good) begin
                cmd_q    <= cmd_sh;
                op_q     <= op_sh;
                seq_q    <= seq_sh;
                stb_q    <= ~stb_q;
                tx_stb_q <= ~tx_stb_q;
                good_q   <= good_q + 16'd1;
            end
            if (commit_bad)
                bad_q <= bad_q + 16'd1;
        end
    end

    assign bus.command    = cmd_q;
    assign bus.opcode     = op_q;
    assign bus.seqnum     = seq_q;
    assign bus.strobe     = stb_q;
    assign bus.tx_strobe  = tx_stb_q;
    assign bus.good_count = good_q;
    assign bus.bad_count  = bad_q;

endmodule

// File: tb/tb_mii_cmd_rx.sv
// Self-checking bench for mii_cmd_rx: vector table, hand-written
// corner sequences and random frames judged by a byte-level model.
module tb_mii_cmd_rx;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mii_cmd_rx_if bus ();

    mii_cmd_rx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int ntot = 0;
    int nbad = 0;

    logic [19:0] e_cmd;
    logic [2:0]  e_op;
    logic [7:0]  e_seq;
    logic        e_stb;
    logic [15:0] e_good;
    logic [15:0] e_bad;

    logic [7:0] fb[$];
    logic [3:0] nq[$];

    typedef struct {
        logic [7:0]  seq;
        logic [2:0]  op;
        logic [19:0] cmd;
        logic [15:0] typ;
        int          len;
        int          corrupt;
        bit          odd;
        bit          exp_good;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        ntot++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: actual=%h required=%h",
                     name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cmd"}, 32'(bus.command), 32'(e_cmd));
        check({tag, ".op"}, 32'(bus.opcode), 32'(e_op));
        check({tag, ".seq"}, 32'(bus.seqnum), 32'(e_seq));
        check({tag, ".stb"}, 32'(bus.strobe), 32'(e_stb));
        check({tag, ".txstb"}, 32'(bus.tx_strobe), 32'(e_stb));
        check({tag, ".good"}, 32'(bus.good_count), 32'(e_good));
        check({tag, ".bad"}, 32'(bus.bad_count), 32'(e_bad));
    endtask

    // Ethernet FCS over n bytes, bytewise reflected CRC-32.
    function automatic logic [31:0] ref_fcs(input logic [7:0] q[$],
                                            input int n);
        logic [31:0] c = 32'hffffffff;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, q[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(input logic [7:0] s, input logic [2:0] o,
                         input logic [19:0] c, input logic [15:0] t,
                         input int len);
        logic [31:0] f;
        fb.delete();
        for (int i = 0; i < 12; i++) fb.push_back(8'($urandom));
        fb.push_back(t[7:0]);
        fb.push_back(t[15:8]);
        fb.push_back(s);
        fb.push_back({5'($urandom), o});
        fb.push_back(c[7:0]);
        fb.push_back(c[15:8]);
        fb.push_back({4'($urandom), c[19:16]});
        while (fb.size() < len - 4) fb.push_back(8'($urandom));
        while (fb.size() > len - 4) void'(fb.pop_back());
        f = ref_fcs(fb, fb.size());
        fb.push_back(f[7:0]);
        fb.push_back(f[15:8]);
        fb.push_back(f[23:16]);
        fb.push_back(f[31:24]);
    endtask

    task automatic make_nibs(input int corrupt, input bit odd);
        nq.delete();
        foreach (fb[i]) begin
            nq.push_back(fb[i][3:0]);
            nq.push_back(fb[i][7:4]);
        end
        if (corrupt >= 0 && corrupt < nq.size())
            nq[corrupt] = nq[corrupt] ^ 4'h1;
        if (odd) nq.push_back(4'($urandom));
    endtask

    task automatic nib(input logic [3:0] v);
        @(negedge clk);
        bus.mii_D  = v;
        bus.mii_DV = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.mii_D  = 4'h0;
            bus.mii_DV = 1'b0;
        end
    endtask

    task automatic preamble();
        repeat (15) nib(4'h5);
        nib(4'hd);
    endtask

    task automatic drive_frame(input int gap);
        preamble();
        foreach (nq[i]) nib(nq[i]);
        idle(gap);
    endtask

    // Judges the received nibble stream from the frame rules alone.
    task automatic model_frame();
        int nn = nq.size();
        int nb = nn / 2;
        bit ok = 1'b0;
        logic [7:0] rb[$];
        for (int i = 0; i < nb; i++)
            rb.push_back({nq[2*i+1], nq[2*i]});
        if (nb > 1518) begin
            e_bad++;
            return;
        end
        if (nn % 2 == 0 && nb >= 23) begin
            if (rb[12] == 8'h55 && rb[13] == 8'h55)
                ok = ref_fcs(rb, nb - 4) ==
                     {rb[nb-1], rb[nb-2], rb[nb-3], rb[nb-4]};
        end
        if (ok) begin
            e_seq = rb[14];
            e_op  = rb[15][2:0];
            e_cmd = {rb[18][3:0], rb[17], rb[16]};
            e_stb = ~e_stb;
            e_good++;
        end else begin
            e_bad++;
        end
    endtask

    task automatic expect_good(input logic [7:0] s,
                               input logic [2:0] o,
                               input logic [19:0] c);
        e_seq = s;
        e_op  = o;
        e_cmd = c;
        e_stb = ~e_stb;
        e_good++;
    endtask

    task automatic zero_exp();
        e_cmd  = '0;
        e_op   = '0;
        e_seq  = '0;
        e_stb  = 1'b0;
        e_good = '0;
        e_bad  = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'h3c, 3'd5, 20'h00012, 16'h5555, 64, 60, 0, 0};
        tbl[1] = '{8'h3c, 3'd5, 20'h00012, 16'h5556, 64, -1, 0, 0};
        tbl[2] = '{8'h11, 3'd1, 20'h11111, 16'h5555, 22, -1, 0, 0};
        tbl[3] = '{8'h3c, 3'd5, 20'h00012, 16'h5555, 64, -1, 1, 0};
        tbl[4] = '{8'h77, 3'd2, 20'habcde, 16'h5555, 23, -1, 0, 1};
        tbl[5] = '{8'h99, 3'd7, 20'hfffff, 16'h5555, 1518, -1, 0, 1};
        tbl[6] = '{8'h42, 3'd3, 20'h12345, 16'h5555, 1519, -1, 0, 0};
        tbl[7] = '{8'h5a, 3'd0, 20'h00001, 16'h5555, 64, 127, 0, 0};
        tbl[8] = '{8'ha5, 3'd6, 20'h80000, 16'h5555, 60, -1, 0, 1};
        tbl[9] = '{8'h01, 3'd4, 20'h0abc0, 16'haaaa, 64, -1, 0, 0};

        bus.mii_D  = 4'h0;
        bus.mii_DV = 1'b0;
        reset      = 1'b1;
        zero_exp();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(2);
        check_all("reset");

        // Good frame with commit latency measured from DV fall.
        build(8'h3c, 3'd5, 20'h00012, 16'h5555, 64);
        make_nibs(-1, 1'b0);
        preamble();
        foreach (nq[i]) nib(nq[i]);
        idle(1);
        @(negedge clk);
        @(negedge clk);
        check("lat_e1.stb", 32'(bus.strobe), 32'd0);
        check("lat_e1.good", 32'(bus.good_count), 32'd0);
        @(negedge clk);
        check("lat_e2.stb", 32'(bus.strobe), 32'd1);
        check("lat_e2.txstb", 32'(bus.tx_strobe), 32'd1);
        expect_good(8'h3c, 3'd5, 20'h00012);
        idle(2);
        check_all("good64");

        for (int i = 0; i < 10; i++) begin
            build(tbl[i].seq, tbl[i].op, tbl[i].cmd,
                  tbl[i].typ, tbl[i].len);
            make_nibs(tbl[i].corrupt, tbl[i].odd);
            drive_frame(1);
            idle(4);
            if (tbl[i].exp_good)
                expect_good(tbl[i].seq, tbl[i].op, tbl[i].cmd);
            else
                e_bad++;
            check_all($sformatf("vec%0d", i));
        end

        // Junk that never reaches BODY is not counted.
        repeat (10) nib(4'h3);
        idle(2);
        repeat (4) nib(4'h5);
        repeat (10) nib(4'h7);
        idle(3);
        check_all("junk");

        // Reset in mid-body with DV held high.
        build(8'hc3, 3'd1, 20'h0f0f0, 16'h5555, 64);
        make_nibs(-1, 1'b0);
        preamble();
        foreach (nq[i]) begin
            if (i == 40) reset = 1'b1;
            if (i == 42) reset = 1'b0;
            nib(nq[i]);
        end
        idle(5);
        zero_exp();
        check_all("midreset");

        build(8'h5e, 3'd3, 20'h54321, 16'h5555, 64);
        make_nibs(-1, 1'b0);
        drive_frame(1);
        idle(4);
        expect_good(8'h5e, 3'd3, 20'h54321);
        check_all("after_reset");

        // Back-to-back with a single idle cycle.
        build(8'h01, 3'd1, 20'h00aa1, 16'h5555, 64);
        make_nibs(-1, 1'b0);
        drive_frame(1);
        build(8'h02, 3'd2, 20'h00aa2, 16'h5555, 64);
        make_nibs(-1, 1'b0);
        drive_frame(1);
        idle(4);
        expect_good(8'h01, 3'd1, 20'h00aa1);
        expect_good(8'h02, 3'd2, 20'h00aa2);
        check_all("b2b");

        for (int r = 0; r < 30; r++) begin
            int len;
            int cor;
            bit odd;
            logic [15:0] t;
            len = $urandom_range(16, 90);
            t   = ($urandom_range(0, 7) == 0) ? 16'h5455 : 16'h5555;
            cor = ($urandom_range(0, 3) == 0)
                ? int'($urandom_range(0, 2 * len - 1)) : -1;
            odd = ($urandom_range(0, 7) == 0);
            build(8'($urandom), 3'($urandom), 20'($urandom), t, len);
            make_nibs(cor, odd);
            drive_frame(int'($urandom_range(1, 3)));
            model_frame();
            idle(4);
            check_all($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
